ysyx_22040895_csr_regfile: RTL and testbench
============================================

YSYX_22040895_CSR_REGFILE -- requirements
Module: ysyx_22040895_csr_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning the width of every CSR and data port.
REQ-002 SHALL have parameter MSTATUS_RST, default 64'h0000_000A_0000_1800, meaning the mstatus reset value (MPP=11, UXL=SXL=2).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port commit_i, input, 1, the current instruction retires this cycle; no architectural update occurs without it.
REQ-006 SHALL have port priv_op_i, input, 3, privileged op: 000 none, 001 ecall, 010 mret, 011 csrrs, 100 csrrw.
REQ-007 SHALL have port csr_addr_i, input, 12, the CSR address for csrrs/csrrw.
REQ-008 SHALL have port csr_wdata_i, input, XLEN, the computed write value for csrrs/csrrw.
REQ-009 SHALL have ports wdata_mepc_i, wdata_mcause_i, wdata_mstatus_i, each input, XLEN, the ecall/mret update values.
REQ-010 SHALL have port csr_rdata_o, output, XLEN, the combinational read of csr_addr_i.
REQ-011 SHALL have ports rdata_mepc_o, rdata_mcause_o, rdata_mtvec_o, rdata_mstatus_o, each output, XLEN, direct register views.
REQ-012 SHALL have port illegal_o, output, 1, csrrs/csrrw to an unimplemented or read-only address.

Function
REQ-013 SHALL implement mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, minstret 0xB02 (read/write), and mhartid 0xF14 (read-only, reads 0).
REQ-014 SHALL drive csr_rdata_o combinationally from the current register value, with no write bypass; a write in cycle N is visible from cycle N+1.
REQ-015 SHALL drive csr_rdata_o=0 for an unimplemented address.
REQ-016 SHALL, on csrrs/csrrw with commit_i=1 to a read/write address, load csr_wdata_i into that CSR at the next edge.
REQ-017 SHALL assert illegal_o combinationally when priv_op_i is 011/100 and the address is unimplemented or 0xF14; no state changes and minstret still increments.
REQ-018 SHALL, on ecall with commit_i=1: mepc<=wdata_mepc_i; mcause<=wdata_mcause_i; mstatus.MPIE<=mstatus.MIE; mstatus.MIE<=0; mstatus.MPP<=2'b11; other mstatus bits unchanged.
REQ-019 SHALL, on mret with commit_i=1, load mstatus<=wdata_mstatus_i; mepc and mcause are unchanged.
REQ-020 SHALL increment mcycle by 1 every cycle regardless of commit_i, wrapping from all-ones to 0.
REQ-021 SHALL increment minstret by 1 on each commit_i=1 cycle, wrapping from all-ones to 0.
REQ-022 SHALL give an explicit CSR write to mcycle/minstret priority over the increment in the same cycle (value = csr_wdata_i, not +1).
REQ-023 SHALL ignore the opcodes 101-111 and all priv_op_i values when commit_i=0, except for the mcycle increment.

Reset
REQ-024 SHALL, while rst_n=0, hold mstatus=MSTATUS_RST and all other CSRs at 0, independent of clk.
REQ-025 SHALL discard any pending write on rst_n assertion mid-cycle and apply no update at the first edge after deassertion unless commit_i=1.
REQ-026 SHALL drive illegal_o combinationally, independent of reset state.

Structure
REQ-027 SHALL place CSR addresses, priv_op encodings, and MSTATUS_RST bit-field positions in the shared package ysyx_22040895_csr_pkg.
REQ-028 SHALL implement mcycle and minstret as two instances of sub-module ysyx_22040895_csr_counter (inc enable, write enable with priority, write data, asynchronous active-low reset).

Verification
REQ-029 Reset then read 0x300 -> 64'h0000_000A_0000_1800; read 0x305 -> 0; mcycle=3 after 3 edges.
REQ-030 csrrw 0x305 data 0x8000_0100 with commit -> rdata_mtvec_o=0x8000_0100 next cycle, unchanged in the same cycle.
REQ-031 mstatus MIE=1, ecall with mepc=0x8000_0010, mcause=11 -> mepc=0x8000_0010, mcause=11, MPIE=1, MIE=0, MPP=11.
REQ-032 mret with wdata_mstatus_i=0x1880 -> mstatus=0x1880; csrrw 0xB00 data 5 in the same cycle as the increment -> mcycle=5, then 6.
REQ-033 csrrw 0xF14 data 7 -> illegal_o=1, read 0xF14 -> 0; minstret=0xFFFF_FFFF_FFFF_FFFF with commit -> wraps to 0.
REQ-034 Pulse rst_n low between edges during a csrrw -> all CSRs at reset values immediately; the write is lost.

Source files
------------

// File: rtl/ysyx_22040895_csr_pkg.sv
// Shared CSR definitions for the machine-mode CSR register file.
// Holds the CSR addresses, privileged-op encodings and mstatus field positions.
package ysyx_22040895_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  typedef enum logic [2:0] {
    PRIV_NONE  = 3'b000,
    PRIV_ECALL = 3'b001,
    PRIV_MRET  = 3'b010,
    PRIV_CSRRS = 3'b011,
    PRIV_CSRRW = 3'b100
  } priv_op_e;

  // mstatus field positions
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LO   = 11;
  localparam int MSTATUS_MPP_HI   = 12;
  localparam int MSTATUS_UXL_LO   = 32;
  localparam int MSTATUS_SXL_LO   = 34;

  localparam logic [63:0] MSTATUS_RST_DEFAULT =
      (64'd3 << MSTATUS_MPP_LO) | (64'd2 << MSTATUS_UXL_LO) | (64'd2 << MSTATUS_SXL_LO);

  function automatic logic csr_is_rw(input logic [11:0] addr);
    return (addr == CSR_MSTATUS)  || (addr == CSR_MTVEC)  ||
           (addr == CSR_MSCRATCH) || (addr == CSR_MEPC)   ||
           (addr == CSR_MCAUSE)   || (addr == CSR_MCYCLE) ||
           (addr == CSR_MINSTRET);
  endfunction

endpackage

// File: rtl/ysyx_22040895_csr_counter.sv
// Free-running CSR counter with an increment enable and a write port.
// A write in the same cycle as an increment wins and loads wdata unmodified.
module ysyx_22040895_csr_counter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc_en,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (wr_en) begin
      count <= wdata;
    end else if (inc_en) begin
      count <= count + {{(XLEN-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/ysyx_22040895_csr_regfile.sv
// Machine-mode CSR register file: explicit csrrs/csrrw access, ecall/mret
// trap bookkeeping, and the mcycle/minstret performance counters.
module ysyx_22040895_csr_regfile
  import ysyx_22040895_csr_pkg::*;
#(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] MSTATUS_RST = 64'h0000_000A_0000_1800
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            commit_i,
  input  logic [2:0]      priv_op_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  input  logic [XLEN-1:0] wdata_mepc_i,
  input  logic [XLEN-1:0] wdata_mcause_i,
  input  logic [XLEN-1:0] wdata_mstatus_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic [XLEN-1:0] rdata_mepc_o,
  output logic [XLEN-1:0] rdata_mcause_o,
  output logic [XLEN-1:0] rdata_mtvec_o,
  output logic [XLEN-1:0] rdata_mstatus_o,
  output logic            illegal_o
);

  logic [XLEN-1:0] mstatus;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mscratch;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mcycle;
  logic [XLEN-1:0] minstret;

  logic is_csr_op;
  logic addr_rw;
  logic csr_we;
  logic do_ecall;
  logic do_mret;

  assign is_csr_op = (priv_op_i == PRIV_CSRRS) || (priv_op_i == PRIV_CSRRW);
  assign addr_rw   = csr_is_rw(csr_addr_i);
  // mhartid is implemented but read-only, so it is illegal to target with a write op
  assign illegal_o = is_csr_op && !addr_rw;
  assign csr_we    = commit_i && is_csr_op && addr_rw;
  assign do_ecall  = commit_i && (priv_op_i == PRIV_ECALL);
  assign do_mret   = commit_i && (priv_op_i == PRIV_MRET);

  always_comb begin
    csr_rdata_o = '0;
    unique case (csr_addr_i)
      CSR_MSTATUS:  csr_rdata_o = mstatus;
      CSR_MTVEC:    csr_rdata_o = mtvec;
      CSR_MSCRATCH: csr_rdata_o = mscratch;
      CSR_MEPC:     csr_rdata_o = mepc;
      CSR_MCAUSE:   csr_rdata_o = mcause;
      CSR_MCYCLE:   csr_rdata_o = mcycle;
      CSR_MINSTRET: csr_rdata_o = minstret;
      default:      csr_rdata_o = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus <= MSTATUS_RST;
    end else if (csr_we && (csr_addr_i == CSR_MSTATUS)) begin
      mstatus <= csr_wdata_i;
    end else if (do_ecall) begin
      mstatus[MSTATUS_MPIE_BIT]              <= mstatus[MSTATUS_MIE_BIT];
      mstatus[MSTATUS_MIE_BIT]               <= 1'b0;
      mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
    end else if (do_mret) begin
      mstatus <= wdata_mstatus_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtvec    <= '0;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
    end else begin
      if (csr_we && (csr_addr_i == CSR_MTVEC))    mtvec    <= csr_wdata_i;
      if (csr_we && (csr_addr_i == CSR_MSCRATCH)) mscratch <= csr_wdata_i;
      if (csr_we && (csr_addr_i == CSR_MEPC)) begin
        mepc <= csr_wdata_i;
      end else if (do_ecall) begin
        mepc <= wdata_mepc_i;
      end
      if (csr_we && (csr_addr_i == CSR_MCAUSE)) begin
        mcause <= csr_wdata_i;
      end else if (do_ecall) begin
        mcause <= wdata_mcause_i;
      end
    end
  end

  ysyx_22040895_csr_counter #(.XLEN(XLEN)) u_mcycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_en(1'b1),
    .wr_en (csr_we && (csr_addr_i == CSR_MCYCLE)),
    .wdata (csr_wdata_i),
    .count (mcycle)
  );

  ysyx_22040895_csr_counter #(.XLEN(XLEN)) u_minstret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_en(commit_i),
    .wr_en (csr_we && (csr_addr_i == CSR_MINSTRET)),
    .wdata (csr_wdata_i),
    .count (minstret)
  );

  assign rdata_mepc_o    = mepc;
  assign rdata_mcause_o  = mcause;
  assign rdata_mtvec_o   = mtvec;
  assign rdata_mstatus_o = mstatus;

endmodule

// File: tb/tb_ysyx_22040895_csr_regfile.sv
// Directed self-checking bench for the CSR register file.
// Expected values are hand-computed constants for each step.
module tb_ysyx_22040895_csr_regfile;

  logic        clk;
  logic        rst_n;
  logic        commit_i;
  logic [2:0]  priv_op_i;
  logic [11:0] csr_addr_i;
  logic [63:0] csr_wdata_i;
  logic [63:0] wdata_mepc_i;
  logic [63:0] wdata_mcause_i;
  logic [63:0] wdata_mstatus_i;
  logic [63:0] csr_rdata_o;
  logic [63:0] rdata_mepc_o;
  logic [63:0] rdata_mcause_o;
  logic [63:0] rdata_mtvec_o;
  logic [63:0] rdata_mstatus_o;
  logic        illegal_o;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] RST_MSTATUS = 64'h0000_000A_0000_1800;
  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_ECALL = 3'b001;
  localparam logic [2:0] OP_MRET  = 3'b010;
  localparam logic [2:0] OP_CSRRS = 3'b011;
  localparam logic [2:0] OP_CSRRW = 3'b100;

  ysyx_22040895_csr_regfile dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .commit_i       (commit_i),
    .priv_op_i      (priv_op_i),
    .csr_addr_i     (csr_addr_i),
    .csr_wdata_i    (csr_wdata_i),
    .wdata_mepc_i   (wdata_mepc_i),
    .wdata_mcause_i (wdata_mcause_i),
    .wdata_mstatus_i(wdata_mstatus_i),
    .csr_rdata_o    (csr_rdata_o),
    .rdata_mepc_o   (rdata_mepc_o),
    .rdata_mcause_o (rdata_mcause_o),
    .rdata_mtvec_o  (rdata_mtvec_o),
    .rdata_mstatus_o(rdata_mstatus_o),
    .illegal_o      (illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [2:0] op, input logic [11:0] addr,
                               input logic [63:0] wdata, input logic commit);
    priv_op_i   = op;
    csr_addr_i  = addr;
    csr_wdata_i = wdata;
    commit_i    = commit;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkRead(input string tag, input logic [11:0] addr,
                           input logic [63:0] expected);
    csr_addr_i = addr;
    #1;
    checkOutput(tag, csr_rdata_o, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n           = 1'b0;
    wdata_mepc_i    = '0;
    wdata_mcause_i  = '0;
    wdata_mstatus_i = '0;
    applyStimulus(OP_NONE, 12'h000, 64'h0, 1'b0);
    #12;
    checkOutput("rst_mstatus", rdata_mstatus_o, RST_MSTATUS);
    checkRead("rst_mcycle", 12'hB00, 64'h0);
    rst_n = 1'b1;

    tick(); tick(); tick();
    checkRead("read_300", 12'h300, RST_MSTATUS);
    checkRead("read_305", 12'h305, 64'h0);
    checkRead("mcycle_3", 12'hB00, 64'd3);
    checkRead("minstret_0", 12'hB02, 64'd0);
    checkRead("unimpl_read", 12'h7C0, 64'h0);

    applyStimulus(OP_CSRRW, 12'h305, 64'h8000_0100, 1'b1);
    #1;
    checkOutput("mtvec_same_cycle", rdata_mtvec_o, 64'h0);
    checkOutput("mtvec_legal", {63'd0, illegal_o}, 64'd0);
    tick();
    checkOutput("mtvec_next_cycle", rdata_mtvec_o, 64'h8000_0100);
    applyStimulus(OP_NONE, 12'h000, 64'h0, 1'b0);
    checkRead("minstret_1", 12'hB02, 64'd1);

    applyStimulus(OP_CSRRW, 12'h300, 64'h0000_000A_0000_1808, 1'b1);
    tick();
    checkOutput("mstatus_mie_set", rdata_mstatus_o, 64'h0000_000A_0000_1808);
    wdata_mepc_i   = 64'h8000_0010;
    wdata_mcause_i = 64'd11;
    applyStimulus(OP_ECALL, 12'h000, 64'h0, 1'b1);
    tick();
    checkOutput("ecall_mepc", rdata_mepc_o, 64'h8000_0010);
    checkOutput("ecall_mcause", rdata_mcause_o, 64'd11);
    checkOutput("ecall_mstatus", rdata_mstatus_o, 64'h0000_000A_0000_1880);

    wdata_mepc_i    = 64'h1234;
    wdata_mcause_i  = 64'h5;
    wdata_mstatus_i = 64'h1880;
    applyStimulus(OP_MRET, 12'h000, 64'h0, 1'b1);
    tick();
    checkOutput("mret_mstatus", rdata_mstatus_o, 64'h1880);
    checkOutput("mret_mepc_kept", rdata_mepc_o, 64'h8000_0010);
    checkOutput("mret_mcause_kept", rdata_mcause_o, 64'd11);

    applyStimulus(OP_CSRRW, 12'hB00, 64'd5, 1'b1);
    tick();
    applyStimulus(OP_NONE, 12'h000, 64'h0, 1'b0);
    checkRead("mcycle_write", 12'hB00, 64'd5);
    tick();
    checkRead("mcycle_inc", 12'hB00, 64'd6);

    applyStimulus(OP_CSRRW, 12'hF14, 64'd7, 1'b1);
    #1;
    checkOutput("mhartid_illegal", {63'd0, illegal_o}, 64'd1);
    checkOutput("mhartid_read", csr_rdata_o, 64'h0);
    tick();
    applyStimulus(OP_NONE, 12'h000, 64'h0, 1'b0);
    checkRead("mhartid_after", 12'hF14, 64'h0);
    checkRead("minstret_illegal", 12'hB02, 64'd6);

    applyStimulus(OP_CSRRS, 12'h123, 64'hFF, 1'b0);
    #1;
    checkOutput("unimpl_illegal", {63'd0, illegal_o}, 64'd1);
    applyStimulus(OP_CSRRS, 12'h340, 64'h55, 1'b0);
    tick();
    checkRead("mscratch_nocommit", 12'h340, 64'h0);
    applyStimulus(OP_CSRRS, 12'h340, 64'h55, 1'b1);
    tick();
    applyStimulus(OP_NONE, 12'h000, 64'h0, 1'b0);
    checkRead("mscratch_commit", 12'h340, 64'h55);

    applyStimulus(OP_CSRRW, 12'hB02, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    tick();
    applyStimulus(OP_NONE, 12'h000, 64'h0, 1'b1);
    checkRead("minstret_max", 12'hB02, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    applyStimulus(OP_NONE, 12'h000, 64'h0, 1'b0);
    checkRead("minstret_wrap", 12'hB02, 64'h0);

    applyStimulus(OP_CSRRW, 12'h305, 64'hDEAD, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("pulse_mtvec", rdata_mtvec_o, 64'h0);
    checkOutput("pulse_mstatus", rdata_mstatus_o, RST_MSTATUS);
    checkOutput("pulse_mepc", rdata_mepc_o, 64'h0);
    checkOutput("pulse_illegal", {63'd0, illegal_o}, 64'd0);
    applyStimulus(OP_CSRRW, 12'hF14, 64'h0, 1'b0);
    #1;
    checkOutput("pulse_illegal_f14", {63'd0, illegal_o}, 64'd1);
    applyStimulus(OP_NONE, 12'h000, 64'h0, 1'b0);
    checkRead("pulse_mcycle", 12'hB00, 64'h0);
    rst_n = 1'b1;
    tick();
    checkOutput("post_pulse_mtvec", rdata_mtvec_o, 64'h0);
    checkRead("post_pulse_mcycle", 12'hB00, 64'd1);
    checkRead("post_pulse_minstret", 12'hB02, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
